// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller.
package ttt_pkg;

  localparam int unsigned N_CELLS   = 9;
  localparam logic [3:0]  LAST_CELL = 4'd8;

  typedef enum logic [2:0] {
    S_PLAY   = 3'd0,
    S_COMMIT = 3'd1,
    S_CHECK  = 3'd2,
    S_OVER   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Rows, columns, then the two diagonals.
  localparam logic [7:0][N_CELLS-1:0] WIN_LINES = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  function automatic logic has_win(input logic [N_CELLS-1:0] marks);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((marks & WIN_LINES[i]) == WIN_LINES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser followed by a registered rising-edge pulse.
module btn_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic ev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      ev_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      ev_q   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign ev_o = ev_q;

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: cursor, mark placement, turn and result tracking.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic        FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_place,
  input  logic       btn_new,
  output logic [3:0] sel,
  output logic       wr_en,
  output logic       player,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       reject,
  output logic       game_over,
  output logic [1:0] winner
);

  logic ev_next, ev_prev, ev_place, ev_new;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next  (.clk(clk), .rst_n(rst_n), .btn_i(btn_next),  .ev_o(ev_next));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_prev  (.clk(clk), .rst_n(rst_n), .btn_i(btn_prev),  .ev_o(ev_prev));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_place (.clk(clk), .rst_n(rst_n), .btn_i(btn_place), .ev_o(ev_place));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_new   (.clk(clk), .rst_n(rst_n), .btn_i(btn_new),   .ev_o(ev_new));

  state_t               state_q, state_d;
  winner_t              winner_q, winner_d;
  logic [3:0]           sel_q, sel_d;
  logic                 player_q, player_d;
  logic [N_CELLS-1:0]   bx_q, bx_d, bo_q, bo_d;
  logic                 reject_q, reject_d;
  logic [N_CELLS-1:0]   sel_mask;
  logic                 cursor_ok;

  assign sel_mask  = 9'b1 << sel_q;
  assign cursor_ok = (state_q == S_PLAY) || (state_q == S_OVER);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    sel_d    = sel_q;
    player_d = player_q;
    bx_d     = bx_q;
    bo_d     = bo_q;
    reject_d = 1'b0;

    // Cursor only moves when no higher-priority event fires; next+prev cancel.
    if (cursor_ok && !ev_new && !ev_place && (ev_next ^ ev_prev)) begin
      if (ev_next) sel_d = (sel_q == LAST_CELL) ? '0 : sel_q + 4'd1;
      else         sel_d = (sel_q == '0) ? LAST_CELL : sel_q - 4'd1;
    end

    case (state_q)
      S_PLAY: begin
        if (ev_new) begin
          state_d = S_CLEAR;
        end else if (ev_place) begin
          if (((bx_q | bo_q) & sel_mask) != '0) reject_d = 1'b1;
          else                                  state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (player_q) bo_d = bo_q | sel_mask;
        else          bx_d = bx_q | sel_mask;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (has_win(player_q ? bo_q : bx_q)) begin
          winner_d = player_q ? WIN_O : WIN_X;
          state_d  = S_OVER;
        end else if (&(bx_q | bo_q)) begin
          winner_d = WIN_DRAW;
          state_d  = S_OVER;
        end else begin
          player_d = ~player_q;
          state_d  = S_PLAY;
        end
      end
      S_OVER: begin
        if (ev_new) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bx_d     = '0;
        bo_d     = '0;
        winner_d = WIN_NONE;
        player_d = FIRST_PLAYER;
        state_d  = S_PLAY;
      end
      default: state_d = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PLAY;
      winner_q <= WIN_NONE;
      sel_q    <= '0;
      player_q <= FIRST_PLAYER;
      bx_q     <= '0;
      bo_q     <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      sel_q    <= sel_d;
      player_q <= player_d;
      bx_q     <= bx_d;
      bo_q     <= bo_d;
      reject_q <= reject_d;
    end
  end

  assign sel       = sel_q;
  assign wr_en     = (state_q == S_COMMIT);
  assign player    = player_q;
  assign board_x   = bx_q;
  assign board_o   = bo_q;
  assign reject    = reject_q;
  assign game_over = (state_q == S_OVER);
  assign winner    = winner_q;

endmodule
